// File: rtl/bsg_cgol_pkg.sv
// Shared link protocol definitions for the job transmitter and the accelerator-side receiver.
package bsg_cgol_pkg;

  localparam int LINK_W         = 64;
  localparam int HDR_SEP_LSB    = 0;
  localparam int HDR_SEP_W      = 24;
  localparam int HDR_FRAMES_LSB = 24;
  localparam int HDR_FRAMES_W   = 40;

  typedef enum logic [1:0] {IDLE, HDR, BODY} tx_state_e;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  // Number of link words needed to carry a w x w board.
  function automatic int body_words(input int w);
    return (w * w + LINK_W - 1) / LINK_W;
  endfunction

endpackage

// File: rtl/bsg_cgol_job_tx_if.sv
// Job-in / word-out bundle of the job transmitter; slave = transmitter, master = host/harness.
interface bsg_cgol_job_tx_if #(
  parameter int board_width_p = 8,
  parameter int frames_w_p    = 4
);
  import bsg_cgol_pkg::*;

  logic                                   job_v_i;
  logic                                   job_ready_o;
  logic [board_width_p*board_width_p-1:0] board_i;
  logic [frames_w_p-1:0]                  frames_i;
  logic [HDR_SEP_W-1:0]                   start_end_point_i;
  logic [LINK_W-1:0]                      data_o;
  logic                                   v_o;
  logic                                   ready_i;
  logic                                   busy_o;
  logic                                   done_o;

  modport slave (
    input  job_v_i, board_i, frames_i, start_end_point_i, ready_i,
    output job_ready_o, data_o, v_o, busy_o, done_o
  );

  modport master (
    output job_v_i, board_i, frames_i, start_end_point_i, ready_i,
    input  job_ready_o, data_o, v_o, busy_o, done_o
  );

endinterface

// File: rtl/bsg_cgol_tx_word_sel.sv
// Picks body word idx out of the captured board, zero-padding past the last cell.
module bsg_cgol_tx_word_sel
  import bsg_cgol_pkg::*;
#(
  parameter int cells_p = 64,
  parameter int words_p = 1,
  parameter int idx_w_p = 1
) (
  input  logic [cells_p-1:0] board_i,
  input  logic [idx_w_p-1:0] idx_i,
  output logic [LINK_W-1:0]  word_o
);

  logic [words_p*LINK_W-1:0] flat;

  always_comb begin
    flat               = '0;
    flat[cells_p-1:0]  = board_i;
    word_o             = '0;
    if (int'(idx_i) < words_p)
      word_o = flat[int'(idx_i)*LINK_W +: LINK_W];
  end

endmodule

// File: rtl/bsg_cgol_job_tx.sv
// Host-side job transmitter: captures one job, streams header + board words over valid/ready.
module bsg_cgol_job_tx
  import bsg_cgol_pkg::*;
#(
  parameter int board_width_p     = 8,
  parameter int max_game_length_p = 10
) (
  input  logic                clk_i,
  input  logic                reset_i,
  bsg_cgol_job_tx_if.slave    link
);

  localparam int CELLS = board_width_p * board_width_p;
  localparam int FW    = safe_clog2(max_game_length_p + 1);
  localparam int B     = body_words(board_width_p);
  localparam int IW    = safe_clog2(B);

  tx_state_e          state_q;
  logic [IW-1:0]      idx_q;
  logic [CELLS-1:0]   board_q;
  logic [LINK_W-1:0]  data_q;
  logic               v_q;
  logic               job_ready_q;

  logic [LINK_W-1:0]  hdr_d;
  logic [LINK_W-1:0]  body_word;
  logic [IW-1:0]      sel_idx;
  logic               capture, xfer, last;

  assign capture = link.job_v_i & job_ready_q;
  assign xfer    = v_q & link.ready_i;
  assign last    = (idx_q == IW'(B - 1));
  // data_q is loaded one word ahead, so select the word that goes out next.
  assign sel_idx = (state_q == HDR) ? '0 : idx_q + 1'b1;

  always_comb begin
    hdr_d                              = '0;
    hdr_d[HDR_SEP_LSB +: HDR_SEP_W]    = link.start_end_point_i;
    hdr_d[HDR_FRAMES_LSB +: FW]        = link.frames_i;
  end

  bsg_cgol_tx_word_sel #(
    .cells_p (CELLS),
    .words_p (B),
    .idx_w_p (IW)
  ) u_word_sel (
    .board_i (board_q),
    .idx_i   (sel_idx),
    .word_o  (body_word)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      board_q     <= '0;
      data_q      <= '0;
      v_q         <= 1'b0;
      job_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          job_ready_q <= 1'b1;
          if (capture) begin
            state_q     <= HDR;
            job_ready_q <= 1'b0;
            v_q         <= 1'b1;
            data_q      <= hdr_d;
            board_q     <= link.board_i;
          end
        end
        HDR: if (xfer) begin
          state_q <= BODY;
          idx_q   <= '0;
          data_q  <= body_word;
        end
        BODY: if (xfer) begin
          if (last) begin
            state_q     <= IDLE;
            v_q         <= 1'b0;
            data_q      <= '0;
            job_ready_q <= 1'b1;
          end else begin
            idx_q  <= idx_q + 1'b1;
            data_q <= body_word;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign link.job_ready_o = job_ready_q;
  assign link.v_o         = v_q;
  assign link.data_o      = data_q;
  assign link.busy_o      = (state_q != IDLE);
  assign link.done_o      = (state_q == BODY) & xfer & last;

endmodule

// File: tb/tb_bsg_cgol_job_tx.sv
// Randomized bench for bsg_cgol_job_tx at W=8 and W=10 against a word-list reference model.
module tb_bsg_cgol_job_tx;

  logic clk, rst_n, armed;
  int   n_tests = 0, n_fail = 0;
  int   rmode [2];

  // expected word list of the job in flight, per DUT
  logic [63:0] ew [2][4];
  int          ecnt [2], eptr [2];

  bsg_cgol_job_tx_if #(.board_width_p(8),  .frames_w_p(4)) if8  ();
  bsg_cgol_job_tx_if #(.board_width_p(10), .frames_w_p(4)) if10 ();

  bsg_cgol_job_tx #(.board_width_p(8),  .max_game_length_p(10)) dut8  (
    .clk_i(clk), .reset_i(rst_n), .link(if8));
  bsg_cgol_job_tx #(.board_width_p(10), .max_game_length_p(10)) dut10 (
    .clk_i(clk), .reset_i(rst_n), .link(if10));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) armed <= 1'b0; else armed <= 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One negedge of the reference model: compare, then retire/enqueue words.
  task automatic mon(input int d, input logic v, rdy, dn, jr, jv, bsy,
                     input logic [63:0] dat, input logic [255:0] brd, input int w,
                     input logic [3:0] fr, input logic [23:0] sp);
    string p;
    int    pend, nb;
    logic  x;
    p = (d == 0) ? "w8" : "w10";
    if (!rst_n) begin
      chk({p, ".rst_v"},     64'(v),   64'd0);
      chk({p, ".rst_ready"}, 64'(jr),  64'd0);
      chk({p, ".rst_busy"},  64'(bsy), 64'd0);
      chk({p, ".rst_done"},  64'(dn),  64'd0);
      chk({p, ".rst_data"},  dat,      64'd0);
      ecnt[d] = 0; eptr[d] = 0;
    end else begin
      pend = ecnt[d] - eptr[d];
      x    = v & rdy;
      chk({p, ".v_o"},         64'(v),   64'(pend != 0));
      chk({p, ".busy_o"},      64'(bsy), 64'(pend != 0));
      chk({p, ".job_ready_o"}, 64'(jr),  64'(armed && pend == 0));
      chk({p, ".done_o"},      64'(dn),  64'(x && pend == 1));
      if (v && pend != 0) chk({p, ".data_o"}, dat, ew[d][eptr[d]]);
      if (x && pend != 0) eptr[d]++;
      if (jv && jr && pend == 0) begin
        nb = (w * w + 63) / 64;
        ew[d][0] = (64'(fr) << 24) | 64'(sp);
        for (int k = 0; k < nb; k++)
          for (int j = 0; j < 64; j++)
            ew[d][k+1][j] = (64 * k + j < w * w) ? brd[64 * k + j] : 1'b0;
        ecnt[d] = nb + 1; eptr[d] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if8.v_o, if8.ready_i, if8.done_o, if8.job_ready_o, if8.job_v_i, if8.busy_o,
        if8.data_o, 256'(if8.board_i), 8, if8.frames_i, if8.start_end_point_i);
    mon(1, if10.v_o, if10.ready_i, if10.done_o, if10.job_ready_o, if10.job_v_i, if10.busy_o,
        if10.data_o, 256'(if10.board_i), 10, if10.frames_i, if10.start_end_point_i);
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rmode[0] != 2) if8.ready_i  = (rmode[0] == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (rmode[1] != 2) if10.ready_i = (rmode[1] == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  task automatic drive(input int d, input logic [255:0] b, input logic [3:0] f,
                       input logic [23:0] s, input logic jv);
    if (d == 0) begin
      if8.board_i = b[63:0]; if8.frames_i = f; if8.start_end_point_i = s; if8.job_v_i = jv;
    end else begin
      if10.board_i = b[99:0]; if10.frames_i = f; if10.start_end_point_i = s; if10.job_v_i = jv;
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Wait (bounded) for the DUT to take the job already on its inputs, then scramble them.
  task automatic wait_capture(input int d);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (d == 0) ? if8.job_ready_o : if10.job_ready_o;
    end
    if (!got) chk("capture_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    drive(d, rnd256(), 4'($urandom_range(0, 10)), 24'($urandom()), 1'b0);
  endtask

  task automatic send(input int d, input logic [255:0] b, input logic [3:0] f, input logic [23:0] s);
    @(posedge clk); #1;
    drive(d, b, f, s, 1'b1);
    wait_capture(d);
  endtask

  task automatic wait_idle(input int d);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 500 && !idle; i++) begin
      @(negedge clk);
      idle = (d == 0) ? !if8.busy_o : !if10.busy_o;
    end
    if (!idle) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rmode[0] = 0; rmode[1] = 0;
    if8.ready_i = 1'b1; if10.ready_i = 1'b1;
    drive(0, '0, '0, '0, 1'b0);
    drive(1, '0, '0, '0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // W=8 directed job, ready held high
    send(0, 256'h0F0F0_0000_0000_000F, 4'd5, 24'h0410C3);
    @(negedge clk); chk("t1.hdr",  if8.data_o, 64'h0000_0000_0504_10C3);
    @(negedge clk); chk("t1.body", if8.data_o, 64'hF0F0_0000_0000_000F);
                    chk("t1.done", 64'(if8.done_o), 64'd1);
    @(negedge clk); chk("t1.ready_back", 64'(if8.job_ready_o), 64'd1);

    // W=10 all-ones: second body word keeps only 36 cells
    send(1, {156'd0, {100{1'b1}}}, 4'd10, 24'hABCDEF);
    @(negedge clk);
    @(negedge clk); chk("t2.body0", if10.data_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk); chk("t2.body1", if10.data_o, 64'h0000_000F_FFFF_FFFF);
                    chk("t2.done",  64'(if10.done_o), 64'd1);
    wait_idle(1);

    // backpressure: 3 stalled cycles in HDR, 2 in BODY
    rmode[1] = 2; if10.ready_i = 1'b0;
    send(1, rnd256(), 4'd3, 24'($urandom()));
    repeat (3) @(posedge clk);
    #1 if10.ready_i = 1'b1;
    @(posedge clk); #1 if10.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 if10.ready_i = 1'b1; rmode[1] = 0;
    wait_idle(1);

    // job_v held through a transmission with different data
    send(1, rnd256(), 4'd7, 24'($urandom()));
    drive(1, rnd256(), 4'd2, 24'($urandom()), 1'b1);
    wait_capture(1);
    wait_idle(1);

    // async reset in the middle of BODY
    rmode[1] = 2; if10.ready_i = 1'b1;
    send(1, rnd256(), 4'd9, 24'($urandom()));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk("t5.v_async", 64'(if10.v_o), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    rmode[1] = 0;
    send(1, rnd256(), 4'd4, 24'($urandom()));
    wait_idle(1);

    // random jobs and random ready on both widths concurrently
    fork
      begin
        for (int n = 0; n < 15; n++) begin
          rmode[0] = $urandom_range(0, 1);
          send(0, rnd256(), 4'($urandom_range(0, 10)), 24'($urandom()));
          wait_idle(0);
        end
      end
      begin
        for (int m = 0; m < 15; m++) begin
          rmode[1] = $urandom_range(0, 1);
          send(1, rnd256(), 4'($urandom_range(0, 10)), 24'($urandom()));
          wait_idle(1);
        end
      end
    join

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
